// File: rtl/riscv_insn_types_pkg.sv
// RV32I instruction types, opcode constants and the combinational decoder
// shared by the decode stage and its users.
package riscv_insn_types;

  localparam int RISCV_XLEN = 32;

  typedef logic [31:0] insn_t;

  typedef enum logic [2:0] {
    RISCV_INSN_TYPE_R       = 3'd0,
    RISCV_INSN_TYPE_I       = 3'd1,
    RISCV_INSN_TYPE_S       = 3'd2,
    RISCV_INSN_TYPE_B       = 3'd3,
    RISCV_INSN_TYPE_U       = 3'd4,
    RISCV_INSN_TYPE_J       = 3'd5,
    RISCV_INSN_TYPE_ILLEGAL = 3'd6
  } insn_type_e;

  // Base opcodes; every legal one ends in 2'b11, so an opcode match also
  // implies a 32-bit (non-compressed) encoding.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    insn_type_e                itype;
    logic [6:0]                opcode;
    logic [4:0]                rd;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [RISCV_XLEN-1:0]     imm;
  } insn_info_t;

  function automatic logic is_type_r(input logic [6:0] opcode);
    return opcode == OPC_OP;
  endfunction

  function automatic logic is_type_i(input logic [6:0] opcode);
    return (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
           (opcode == OPC_JALR)   || (opcode == OPC_SYSTEM);
  endfunction

  function automatic logic is_type_s(input logic [6:0] opcode);
    return opcode == OPC_STORE;
  endfunction

  function automatic logic is_type_b(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

  function automatic logic is_type_u(input logic [6:0] opcode);
    return (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
  endfunction

  function automatic logic is_type_j(input logic [6:0] opcode);
    return opcode == OPC_JAL;
  endfunction

  // Fields a format does not define stay zero; illegal words keep only the opcode.
  function automatic insn_info_t decode_insn(input insn_t insn);
    insn_info_t info;
    logic [6:0] opcode;
    opcode      = insn[6:0];
    info        = '0;
    info.opcode = opcode;
    if (is_type_r(opcode)) begin
      info.itype  = RISCV_INSN_TYPE_R;
      info.rd     = insn[11:7];
      info.rs1    = insn[19:15];
      info.rs2    = insn[24:20];
      info.funct3 = insn[14:12];
      info.funct7 = insn[31:25];
    end else if (is_type_i(opcode)) begin
      info.itype  = RISCV_INSN_TYPE_I;
      info.rd     = insn[11:7];
      info.rs1    = insn[19:15];
      info.funct3 = insn[14:12];
      info.imm    = {{20{insn[31]}}, insn[31:20]};
    end else if (is_type_s(opcode)) begin
      info.itype  = RISCV_INSN_TYPE_S;
      info.rs1    = insn[19:15];
      info.rs2    = insn[24:20];
      info.funct3 = insn[14:12];
      info.imm    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    end else if (is_type_b(opcode)) begin
      info.itype  = RISCV_INSN_TYPE_B;
      info.rs1    = insn[19:15];
      info.rs2    = insn[24:20];
      info.funct3 = insn[14:12];
      info.imm    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    end else if (is_type_u(opcode)) begin
      info.itype  = RISCV_INSN_TYPE_U;
      info.rd     = insn[11:7];
      info.imm    = {insn[31:12], 12'b0};
    end else if (is_type_j(opcode)) begin
      info.itype  = RISCV_INSN_TYPE_J;
      info.rd     = insn[11:7];
      info.imm    = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    end else begin
      info.itype  = RISCV_INSN_TYPE_ILLEGAL;
    end
    return info;
  endfunction

endpackage

// File: rtl/riscv_decode_skid.sv
// Two-entry valid/ready buffer: an output register plus one skid entry.
// in_ready depends only on registered state and flush, never on out_ready.
module riscv_decode_skid #(
  parameter type payload_t = logic [31:0]
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  logic     or_valid_reg, or_valid_next;
  logic     sk_valid_reg, sk_valid_next;
  payload_t or_data_reg,  or_data_next;
  payload_t sk_data_reg,  sk_data_next;
  logic     accept;

  assign in_ready  = !sk_valid_reg && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = or_valid_reg;
  assign out_data  = or_data_reg;

  // Next-state: refill OR from SK first (FIFO order), else from input; spill to SK when OR stalls.
  always_comb begin
    or_valid_next = or_valid_reg;
    or_data_next  = or_data_reg;
    sk_valid_next = sk_valid_reg;
    sk_data_next  = sk_data_reg;
    if (flush) begin
      or_valid_next = 1'b0;
      sk_valid_next = 1'b0;
    end else if (!or_valid_reg || out_ready) begin
      if (sk_valid_reg) begin
        or_valid_next = 1'b1;
        or_data_next  = sk_data_reg;
        sk_valid_next = 1'b0;
      end else if (accept) begin
        or_valid_next = 1'b1;
        or_data_next  = in_data;
      end else begin
        or_valid_next = 1'b0;
      end
    end else if (accept) begin
      sk_valid_next = 1'b1;
      sk_data_next  = in_data;
    end
  end

  // State registers; reset clears valids and data so outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_reg <= 1'b0;
      sk_valid_reg <= 1'b0;
      or_data_reg  <= '0;
      sk_data_reg  <= '0;
    end else begin
      or_valid_reg <= or_valid_next;
      sk_valid_reg <= sk_valid_next;
      or_data_reg  <= or_data_next;
      sk_data_reg  <= sk_data_next;
    end
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: decodes the incoming word combinationally and buffers
// the decoded form (not the raw word) in a two-entry skid buffer.
module riscv_decode_stage
  import riscv_insn_types::*;
#(
  parameter int XLEN = RISCV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  insn_t           in_insn,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output insn_info_t      out_info,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    insn_info_t      info;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } stage_payload_t;

  stage_payload_t in_payload;
  stage_payload_t out_payload;
  insn_info_t     decoded;

  // Decode the incoming word and bundle it with its PC for buffering.
  always_comb begin
    decoded            = decode_insn(in_insn);
    in_payload         = '0;
    in_payload.info    = decoded;
    in_payload.pc      = in_pc;
    in_payload.illegal = (decoded.itype == RISCV_INSN_TYPE_ILLEGAL);
  end

  riscv_decode_skid #(
    .payload_t (stage_payload_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_info    = out_payload.info;
  assign out_pc      = out_payload.pc;
  assign out_illegal = out_payload.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: stimulus pushes expected decodes on
// each input handshake; the monitor pops and compares on each output handshake.
module tb_riscv_decode_stage;
  import riscv_insn_types::*;

  typedef struct packed {
    insn_info_t  info;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  insn_t       in_insn;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  insn_info_t  out_info;
  logic [31:0] out_pc;
  logic        out_illegal;

  int tests_run;
  int tests_failed;
  exp_t exp_q[$];

  insn_t      vec_insn[10];
  insn_info_t vec_exp[10];
  logic       vec_ill[10];

  riscv_decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_insn     (in_insn),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_info    (out_info),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic insn_info_t mk(input insn_type_e t, input logic [6:0] op,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] imm);
    insn_info_t r;
    r.itype = t; r.opcode = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.funct3 = f3; r.funct7 = f7; r.imm = imm;
    return r;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one instruction until accepted; returns cycles spent.
  task automatic send(input int idx, input logic [31:0] pc, output int cyc);
    logic ok;
    exp_t e;
    in_valid = 1'b1;
    in_insn  = vec_insn[idx];
    in_pc    = pc;
    cyc      = 0;
    while (1) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (ok) begin
        e.info = vec_exp[idx]; e.pc = pc; e.illegal = vec_ill[idx];
        exp_q.push_back(e);
        break;
      end
      if (cyc > 50) begin
        chk("send_timeout", 96'(cyc), 96'd0);
        break;
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 96'(out_pc), 96'd0);
          tests_failed += (out_pc == 32'd0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          $display("[TB] out pc=%08h itype=%0d opc=%02h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%02h imm=%08h ill=%0b",
                   out_pc, out_info.itype, out_info.opcode, out_info.rd, out_info.rs1,
                   out_info.rs2, out_info.funct3, out_info.funct7, out_info.imm, out_illegal);
          chk("out_info", 96'(out_info), 96'(e.info));
          chk("out_pc", 96'(out_pc), 96'(e.pc));
          chk("out_illegal", 96'(out_illegal), 96'(e.illegal));
        end
      end
    end
  endtask

  task automatic stimulus();
    int c;
    int total;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_in_ready", 96'(in_ready), 96'd1);
    chk("rst_out_info", 96'(out_info), 96'd0);
    chk("rst_out_pc", 96'(out_pc), 96'd0);
    chk("rst_out_illegal", 96'(out_illegal), 96'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test A: every vector, latency 1, full throughput
    out_ready = 1'b1;
    send(0, 32'h100, c);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_out_valid", 96'(out_valid), 96'd1);
    chk("latency_out_pc", 96'(out_pc), 96'h100);
    @(posedge clk); #1;
    total = 0;
    for (int i = 1; i < 10; i++) begin
      send(i, 32'h100 + 32'(4 * i), c);
      total += c;
    end
    in_valid = 1'b0;
    chk("throughput_cycles", 96'(total), 96'd9);
    repeat (3) @(posedge clk); #1;
    chk("drain_a_empty", 96'(exp_q.size()), 96'd0);

    // Test B: 8-deep stream, out_ready low for cycles 3..5
    total = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(i, 32'h200 + 32'(4 * i), c);
          total += c;
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("stall_stream_cycles", 96'(total), 96'd11);
    repeat (4) @(posedge clk); #1;
    chk("drain_b_empty", 96'(exp_q.size()), 96'd0);

    // Test C: flush with OR and SK full
    out_ready = 1'b0;
    send(1, 32'h300, c);
    send(2, 32'h304, c);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 96'(in_ready), 96'd0);
    chk("full_out_valid", 96'(out_valid), 96'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 96'(in_ready), 96'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_flush_out_valid", 96'(out_valid), 96'd0);
    chk("post_flush_in_ready", 96'(in_ready), 96'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3, 32'h308, c);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("drain_c_empty", 96'(exp_q.size()), 96'd0);

    // Test D: asynchronous reset mid-stream
    out_ready = 1'b0;
    send(4, 32'h400, c);
    send(6, 32'h404, c);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 96'(out_valid), 96'd0);
    chk("async_rst_in_ready", 96'(in_ready), 96'd1);
    chk("async_rst_out_info", 96'(out_info), 96'd0);
    chk("async_rst_out_pc", 96'(out_pc), 96'd0);
    chk("async_rst_out_illegal", 96'(out_illegal), 96'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(5, 32'h500, c);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("final_empty", 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_ready = 1'b0;
    tests_run = 0; tests_failed = 0;
    vec_insn[0] = 32'hFFF10093; vec_exp[0] = mk(RISCV_INSN_TYPE_I, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF);
    vec_insn[1] = 32'h00532423; vec_exp[1] = mk(RISCV_INSN_TYPE_S, 7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 7'h00, 32'h00000008);
    vec_insn[2] = 32'hFE000EE3; vec_exp[2] = mk(RISCV_INSN_TYPE_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC);
    vec_insn[3] = 32'h123451B7; vec_exp[3] = mk(RISCV_INSN_TYPE_U, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
    vec_insn[4] = 32'h001000EF; vec_exp[4] = mk(RISCV_INSN_TYPE_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800);
    vec_insn[5] = 32'h00000000; vec_exp[5] = mk(RISCV_INSN_TYPE_ILLEGAL, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    vec_insn[6] = 32'h0000007F; vec_exp[6] = mk(RISCV_INSN_TYPE_ILLEGAL, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    vec_insn[7] = 32'h40B50533; vec_exp[7] = mk(RISCV_INSN_TYPE_R, 7'h33, 5'd10, 5'd10, 5'd11, 3'd0, 7'h20, 32'h0);
    vec_insn[8] = 32'h00812183; vec_exp[8] = mk(RISCV_INSN_TYPE_I, 7'h03, 5'd3, 5'd2, 5'd0, 3'd2, 7'h00, 32'h00000008);
    vec_insn[9] = 32'h00000073; vec_exp[9] = mk(RISCV_INSN_TYPE_I, 7'h73, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    for (int i = 0; i < 10; i++) vec_ill[i] = (i == 5) || (i == 6);

    fork
      monitor_loop();
      stimulus();
      begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
